// File: rtl/shift_seq_pkg.sv
// ============================================================================
// Module   : shift_seq_pkg
// Brief    : Mode and FSM state encodings shared by the shift sequencer files.
// Revision : 1.0
// ============================================================================
`default_nettype none

package shift_seq_pkg;

  typedef enum logic [1:0] {
    MODE_SHL  = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_NORM = 2'b10,
    MODE_ASR  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_LOAD  = 2'b01,
    S_SHIFT = 2'b10,
    S_DONE  = 2'b11
  } state_e;

endpackage

`default_nettype wire

// File: rtl/shift_seq_counter.sv
// ============================================================================
// Module   : shift_seq_counter
// Brief    : Loadable saturating down-counter (remaining shifts) paired with an
//            up-counter (shifts performed); term_o flags remaining == 0.
// Revision : 1.0
// ============================================================================
`default_nettype none

module shift_seq_counter #(
  parameter int CW = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  input  logic          dec_i,
  output logic [CW-1:0] remaining_o,
  output logic [CW-1:0] count_o,
  output logic          term_o
);

  logic [CW-1:0] remaining_q, remaining_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    remaining_d = remaining_q;
    count_d     = count_q;
    if (load_i) begin
      remaining_d = load_val_i;
      count_d     = '0;
    end else if (dec_i) begin
      // Saturate at zero so a stray decrement can never wrap.
      if (remaining_q != '0) remaining_d = remaining_q - 1'b1;
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      remaining_q <= '0;
      count_q     <= '0;
    end else begin
      remaining_q <= remaining_d;
      count_q     <= count_d;
    end
  end

  assign remaining_o = remaining_q;
  assign count_o     = count_q;
  assign term_o      = (remaining_q == '0);

endmodule

`default_nettype wire

// File: rtl/shift_register_sequencer.sv
// ============================================================================
// Module   : shift_register_sequencer
// Brief    : Sequences one load + N shifts on an external universal shift
//            register and returns the result with a done pulse.
//            Normalize mode (leading-one detect) is built only when
//            SHIFT_SEQ_NORMALIZE_EN is defined; otherwise mode 10 acts as 00.
//            rst_ni is a synchronous active-low reset.
// Revision : 1.0
// ============================================================================
`default_nettype none

module shift_register_sequencer
  import shift_seq_pkg::*;
#(
  parameter int W  = 8,
  parameter int CW = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  output logic          ready_o,
  input  logic [1:0]    mode_i,
  input  logic [CW-1:0] amt_i,
  input  logic          fill_i,
  input  logic [W-1:0]  operand_i,
  output logic          usr_load_o,
  output logic          usr_shift_left_o,
  output logic          usr_shift_right_o,
  output logic          usr_shift_in_o,
  output logic [W-1:0]  usr_d_o,
  input  logic [W-1:0]  usr_q_i,
  output logic [W-1:0]  result_o,
  output logic [CW-1:0] shift_count_o,
  output logic          zero_o,
  output logic          done_o
);

  state_e         state_q;
  mode_e          mode_q;
  mode_e          mode_d;
  logic           fill_q;
  logic [W-1:0]   operand_q;
  logic [W-1:0]   result_q;
  logic           zero_q;

  logic           cnt_load_d;
  logic [CW-1:0]  amt_sat_d;
  logic           shift_d;
  logic           term_d;
  logic           norm_zero_d;
  logic           cnt_term;
  logic [CW-1:0]  remaining;
  logic [CW-1:0]  shift_count;

  assign amt_sat_d  = (amt_i > CW'(W)) ? CW'(W) : amt_i;
  assign cnt_load_d = (state_q == S_IDLE) && start_i;

`ifdef SHIFT_SEQ_NORMALIZE_EN
  assign mode_d = mode_e'(mode_i);
`else
  assign mode_d = (mode_e'(mode_i) == MODE_NORM) ? MODE_SHL : mode_e'(mode_i);
`endif

  shift_seq_counter #(.CW(CW)) u_counter (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .load_i      (cnt_load_d),
    .load_val_i  (amt_sat_d),
    .dec_i       (shift_d),
    .remaining_o (remaining),
    .count_o     (shift_count),
    .term_o      (cnt_term)
  );

  always_comb begin
    term_d      = cnt_term;
    norm_zero_d = 1'b0;
`ifdef SHIFT_SEQ_NORMALIZE_EN
    // shift_count==0 marks the first SHIFT cycle; only then can Q be all-zero.
    if (mode_q == MODE_NORM) begin
      norm_zero_d = (shift_count == '0) && (usr_q_i == '0);
      term_d      = usr_q_i[W-1] || (shift_count == CW'(W-1)) || norm_zero_d;
    end
`endif
  end

  assign shift_d = (state_q == S_SHIFT) && !term_d;

  always_comb begin
    usr_shift_in_o = 1'b0;
    if (shift_d) begin
      case (mode_q)
        MODE_SHL, MODE_SHR: usr_shift_in_o = fill_q;
        MODE_ASR:           usr_shift_in_o = usr_q_i[W-1];
        default:            usr_shift_in_o = 1'b0;
      endcase
    end
  end

  always_comb begin
    usr_d_o = '0;
    if (state_q == S_LOAD)       usr_d_o = operand_q;
    else if (state_q == S_SHIFT) usr_d_o = usr_q_i;
  end

  assign usr_load_o        = (state_q == S_LOAD);
  assign usr_shift_left_o  = shift_d && ((mode_q == MODE_SHL) || (mode_q == MODE_NORM));
  assign usr_shift_right_o = shift_d && ((mode_q == MODE_SHR) || (mode_q == MODE_ASR));
  assign ready_o           = (state_q == S_IDLE);
  assign done_o            = (state_q == S_DONE);
  assign result_o          = result_q;
  assign zero_o            = zero_q;
  assign shift_count_o     = shift_count;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      mode_q    <= MODE_SHL;
      fill_q    <= 1'b0;
      operand_q <= '0;
      result_q  <= '0;
      zero_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            mode_q    <= mode_d;
            fill_q    <= fill_i;
            operand_q <= operand_i;
            zero_q    <= 1'b0;
            state_q   <= S_LOAD;
          end
        end
        S_LOAD:  state_q <= S_SHIFT;
        S_SHIFT: begin
          if (term_d) begin
            result_q <= usr_q_i;
            zero_q   <= norm_zero_d;
            state_q  <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // remaining is consumed only through the counter's terminal flag.
  logic unused_remaining;
  assign unused_remaining = ^remaining;

endmodule

`default_nettype wire

// File: tb/tb_shift_register_sequencer.sv
// ============================================================================
// Module   : tb_shift_register_sequencer
// Brief    : Directed table-driven bench with a behavioural universal shift
//            register closing the usr_d/usr_q loop.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_shift_register_sequencer;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          ready;
  logic [1:0]    mode = 2'b00;
  logic [CW-1:0] amt = '0;
  logic          fill = 1'b0;
  logic [W-1:0]  operand = '0;
  logic          usr_load, usr_left, usr_right, usr_in;
  logic [W-1:0]  usr_d;
  logic [W-1:0]  usr_q = '0;
  logic [W-1:0]  result;
  logic [CW-1:0] shift_count;
  logic          zero;
  logic          done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  shift_register_sequencer #(.W(W), .CW(CW)) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .start_i           (start),
    .ready_o           (ready),
    .mode_i            (mode),
    .amt_i             (amt),
    .fill_i            (fill),
    .operand_i         (operand),
    .usr_load_o        (usr_load),
    .usr_shift_left_o  (usr_left),
    .usr_shift_right_o (usr_right),
    .usr_shift_in_o    (usr_in),
    .usr_d_o           (usr_d),
    .usr_q_i           (usr_q),
    .result_o          (result),
    .shift_count_o     (shift_count),
    .zero_o            (zero),
    .done_o            (done)
  );

  // Universal shift register the sequencer drives.
  always @(posedge clk) begin
    if (usr_load)       usr_q <= usr_d;
    else if (usr_left)  usr_q <= {usr_q[W-2:0], usr_in};
    else if (usr_right) usr_q <= {usr_in, usr_q[W-1:1]};
  end

  always @(negedge clk) begin
    if (rst_n) begin
      tests++;
      if (int'(usr_load) + int'(usr_left) + int'(usr_right) > 1) begin
        fails++;
        $display("FAIL onehot_ctrl: load=%0b left=%0b right=%0b, required at most one", usr_load, usr_left, usr_right);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]    mode;
    logic [CW-1:0] amt;
    logic          fill;
    logic [W-1:0]  op;
    logic [W-1:0]  res;
    logic [CW-1:0] cnt;
    logic          zero;
    int            done_cyc;
    int            nl;
    int            nr;
    int            nin;
  } vec_t;

`ifdef SHIFT_SEQ_NORMALIZE_EN
  localparam logic ZERO_EXP = 1'b1;
`else
  localparam logic ZERO_EXP = 1'b0;
`endif

  vec_t vecs[11];

  task automatic run_vec(input vec_t v, input int idx);
    int cyc, nl, nr, nin;
    string tag;
    tag = $sformatf("v%0d", idx);
    mode = v.mode; amt = v.amt; fill = v.fill; operand = v.op;
    start = 1'b1;
    chk({tag, "_ready_c0"}, 32'(ready), 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    chk({tag, "_load_c1"}, 32'(usr_load), 32'd1);
    nl = 0; nr = 0; nin = 0;
    while (!done && cyc < 40) begin
      if (usr_left)  nl++;
      if (usr_right) nr++;
      if ((usr_left || usr_right) && usr_in) nin++;
      @(posedge clk); #1;
      cyc++;
    end
    if (!done) begin
      fails++;
      tests++;
      $display("FAIL %s_timeout: no done after %0d cycles, expected done in cycle %0d", tag, cyc, v.done_cyc);
    end
    chk({tag, "_done_cyc"}, 32'(cyc), 32'(v.done_cyc));
    chk({tag, "_result"}, 32'(result), 32'(v.res));
    chk({tag, "_count"}, 32'(shift_count), 32'(v.cnt));
    chk({tag, "_zero"}, 32'(zero), 32'(v.zero));
    chk({tag, "_nleft"}, 32'(nl), 32'(v.nl));
    chk({tag, "_nright"}, 32'(nr), 32'(v.nr));
    chk({tag, "_nshiftin"}, 32'(nin), 32'(v.nin));
    chk({tag, "_ready_at_done"}, 32'(ready), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_ready_after"}, 32'(ready), 32'd1);
    chk({tag, "_result_held"}, 32'(result), 32'(v.res));
  endtask

  initial begin
    bit saw_done;

    //         mode   amt    fill  op      res     cnt    zero      cyc nl nr nin
    vecs[0]  = '{2'b00, 4'd3,  1'b0, 8'hB4, 8'hA0, 4'd3, 1'b0,     6,  3, 0, 0};
    vecs[1]  = '{2'b11, 4'd2,  1'b0, 8'h90, 8'hE4, 4'd2, 1'b0,     5,  0, 2, 2};
    vecs[2]  = '{2'b10, 4'd3,  1'b0, 8'h13, 8'h98, 4'd3, 1'b0,     6,  3, 0, 0};
    vecs[3]  = '{2'b10, 4'd0,  1'b0, 8'h00, 8'h00, 4'd0, ZERO_EXP, 3,  0, 0, 0};
    vecs[4]  = '{2'b00, 4'd12, 1'b1, 8'h00, 8'hFF, 4'd8, 1'b0,     11, 8, 0, 8};
    vecs[5]  = '{2'b01, 4'd2,  1'b1, 8'hB4, 8'hED, 4'd2, 1'b0,     5,  0, 2, 2};
    vecs[6]  = '{2'b01, 4'd0,  1'b1, 8'h5A, 8'h5A, 4'd0, 1'b0,     3,  0, 0, 0};
    vecs[7]  = '{2'b11, 4'd8,  1'b1, 8'h80, 8'hFF, 4'd8, 1'b0,     11, 0, 8, 8};
    vecs[8]  = '{2'b11, 4'd1,  1'b1, 8'h40, 8'h20, 4'd1, 1'b0,     4,  0, 1, 0};
    vecs[9]  = '{2'b01, 4'd15, 1'b0, 8'hFF, 8'h00, 4'd8, 1'b0,     11, 0, 8, 0};
    vecs[10] = '{2'b10, 4'd7,  1'b0, 8'h01, 8'h80, 4'd7, 1'b0,     10, 7, 0, 0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_zero", 32'(zero), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_count", 32'(shift_count), 32'd0);
    chk("rst_usr_ctrl", 32'({usr_load, usr_left, usr_right, usr_in}), 32'd0);
    chk("rst_usr_d", 32'(usr_d), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready", 32'(ready), 32'd1);

    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

    // Start while busy is ignored, then reset aborts mid-shift
    saw_done = 1'b0;
    mode = 2'b00; amt = 4'd5; fill = 1'b0; operand = 8'h01;
    start = 1'b1;                                   // cycle 0
    @(posedge clk); #1; start = 1'b0; saw_done |= done;   // cycle 1
    @(posedge clk); #1; saw_done |= done;                  // cycle 2
    @(posedge clk); #1; saw_done |= done;                  // cycle 3
    chk("busy_ready", 32'(ready), 32'd0);
    mode = 2'b01; amt = 4'd1; operand = 8'hFF; start = 1'b1;
    @(posedge clk); #1; saw_done |= done;                  // cycle 4
    start = 1'b0;
    chk("busy_no_reload", 32'(usr_load), 32'd0);
    chk("busy_still_left", 32'(usr_left), 32'd1);
    chk("busy_count", 32'(shift_count), 32'd2);
    rst_n = 1'b0;
    @(posedge clk); #1; saw_done |= done;                  // cycle 5
    chk("abort_usr_ctrl", 32'({usr_load, usr_left, usr_right, usr_in}), 32'd0);
    chk("abort_usr_d", 32'(usr_d), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1; saw_done |= done;                  // cycle 6
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_count", 32'(shift_count), 32'd0);
    chk("abort_no_done", 32'(saw_done), 32'd0);

    run_vec(vecs[0], 11);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
